// File: rtl/bus_nslv.sv
// Single-master, N-slave memory bus: address-decoded posted writes, latency-matched reads.
// Optional build macro BUS_STATS_EN adds saturating read/write/error counters on stat_*.
module bus_nslv #(
  parameter int NSLV    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SEL_MSB = 31,
  parameter int SEL_LSB = 28,
  parameter int RD_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m_req,
  input  logic [DW/8-1:0]        m_we,
  input  logic [AW-1:0]          m_addr,
  input  logic [DW-1:0]          m_wdata,
  output logic                   m_ready,
  output logic                   m_rvalid,
  output logic [DW-1:0]          m_rdata,
  output logic                   m_err,
  output logic [NSLV*AW-1:0]     s_addr,
  output logic [NSLV*DW-1:0]     s_wdata,
  output logic [NSLV*DW/8-1:0]   s_we,
  output logic [NSLV-1:0]        s_re,
  input  logic [NSLV*DW-1:0]     s_rdata,
  output logic [15:0]            stat_rd,
  output logic [15:0]            stat_wr,
  output logic [15:0]            stat_err
);

  localparam int SW = SEL_MSB - SEL_LSB + 1;
  localparam int BW = DW / 8;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] idx_q, idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [SW-1:0] idx;
  logic          mapped;
  logic          is_wr;
  logic          acc;
  logic [AW-1:0] addr_z;
  logic [DW-1:0] sel_rdata;

  always_comb begin
    idx    = m_addr[SEL_MSB:SEL_LSB];
    mapped = ({1'b0, idx} < (SW+1)'(NSLV));
    is_wr  = |m_we;
    acc    = m_req && (state_q == IDLE);
    addr_z = m_addr;
    addr_z[SEL_MSB:SEL_LSB] = '0;
  end

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (idx_q == SW'(k)) sel_rdata = s_rdata[k*DW +: DW];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_req) begin
          if (is_wr) begin
            err_d = !mapped;
          end else if (mapped) begin
            idx_d   = idx;
            addr_d  = addr_z;
            cnt_d   = CW'(RD_LAT - 1);
            state_d = RD_WAIT;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = sel_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Strobes are gated by rst_n so slaves never see a write or read during reset.
  always_comb begin
    s_we = '0;
    s_re = '0;
    for (int k = 0; k < NSLV; k++) begin
      s_addr[k*AW +: AW]  = (state_q == RD_WAIT) ? addr_q : addr_z;
      s_wdata[k*DW +: DW] = m_wdata;
      if (rst_n && acc && mapped && (idx == SW'(k))) begin
        if (is_wr) s_we[k*BW +: BW] = m_we;
        else       s_re[k] = 1'b1;
      end
    end
  end

  assign m_ready  = (state_q == IDLE);
  assign m_rvalid = (state_q == RESP);
  assign m_rdata  = rdata_q;
  assign m_err    = err_q;

`ifdef BUS_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] er_cnt_q, er_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    er_cnt_d = er_cnt_q;
    if (acc) begin
      if (!mapped) begin
        if (er_cnt_q != 16'hFFFF) er_cnt_d = er_cnt_q + 16'd1;
      end else if (is_wr) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      er_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      er_cnt_q <= er_cnt_d;
    end
  end

  assign stat_rd  = rd_cnt_q;
  assign stat_wr  = wr_cnt_q;
  assign stat_err = er_cnt_q;
`else
  assign stat_rd  = '0;
  assign stat_wr  = '0;
  assign stat_err = '0;
`endif

endmodule

// File: tb/tb_bus_nslv.sv
// Bench for bus_nslv: two instances (read latency 1 and 3) share one master driver,
// each backed by a latency-exact slave model, checked every cycle against a transaction-level model.
module tb_bus_nslv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_req = 1'b0;
  int   sel = 0;
  logic [3:0]  m_we = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;

  logic [1:0]        req, ready, rvalid, err;
  logic [1:0][31:0]  rdata;
  logic [1:0][127:0] s_addr, s_wdata;
  logic [1:0][15:0]  s_we, st_rd, st_wr, st_err;
  logic [1:0][3:0]   s_re;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  bit mvalid = 1'b0;

  // {dut, due_cycle[31:0], rvalid, err, rdata[31:0]}
  logic [66:0] exp_q[$];

  int          free_at[2] = '{0, 0};
  int          rw_lo[2]   = '{0, 0};
  int          rw_hi[2]   = '{-1, -1};
  int          lat_idx[2] = '{0, 0};
  logic [31:0] lat_addr[2];
  logic [31:0] last_rd[2];
  int          n_rd[2] = '{0, 0};
  int          n_wr[2] = '{0, 0};
  int          n_er[2] = '{0, 0};

  logic [15:0]  acc_we;
  logic [3:0]   acc_re;
  logic [127:0] acc_addr;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign req[0] = m_req && (sel == 0);
  assign req[1] = m_req && (sel == 1);

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] slave_data(input int k, input logic [31:0] a);
    if (k == 2 && a == 32'h4) return 32'h1234_5678;
    return {4'(k), a[27:0] ^ 28'h5A5_A5A5};
  endfunction

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [127:0] srd;
    logic         sact = 1'b0;
    int           scnt = 0;
    int           sk = 0;
    logic [31:0]  sdat = '0;

    // Slave returns real data only in the single cycle LAT cycles after its read strobe.
    always @(posedge clk) begin
      if (sact) begin
        if (scnt == 0) sact <= 1'b0;
        else           scnt <= scnt - 1;
      end
      for (int k = 0; k < 4; k++) begin
        if (s_re[g][k]) begin
          sact <= 1'b1;
          scnt <= LAT - 1;
          sk   <= k;
          sdat <= slave_data(k, s_addr[g][k*32 +: 32]);
        end
      end
    end

    always_comb begin
      for (int k = 0; k < 4; k++)
        srd[k*32 +: 32] = (sact && scnt == 0 && sk == k) ? sdat : (32'hBAD0_0000 | 32'(k));
    end

    bus_nslv #(.NSLV(4), .AW(32), .DW(32), .SEL_MSB(31), .SEL_LSB(28), .RD_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n), .m_req(req[g]), .m_we(m_we), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_ready(ready[g]), .m_rvalid(rvalid[g]), .m_rdata(rdata[g]),
      .m_err(err[g]), .s_addr(s_addr[g]), .s_wdata(s_wdata[g]), .s_we(s_we[g]),
      .s_re(s_re[g]), .s_rdata(srd), .stat_rd(st_rd[g]), .stat_wr(st_wr[g]),
      .stat_err(st_err[g])
    );
  end

  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc=%0d: got %0h want %0h", nm, d, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input int d, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hold, output int acc);
    sel = d; m_we = we; m_addr = addr; m_wdata = wd; m_req = 1'b1;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready[d]) begin
        acc = cyc; acc_we = s_we[d]; acc_re = s_re[d]; acc_addr = s_addr[d];
        break;
      end
    end
    if (acc < 0) begin
      n_chk++; n_err++;
      $display("FAIL accept_timeout dut%0d addr=%0h: no m_ready within 50 cycles", d, addr);
    end
    @(posedge clk); #1;
    if (!hold) m_req = 1'b0;
  endtask

  // ---------------- scoreboard / per-cycle compare ----------------
  logic        e_rdy, e_acc, e_rv, e_er, e_map;
  int          e_ii;
  logic [31:0] e_az;
  logic [15:0] e_we;
  logic [3:0]  e_re;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      e_rdy = (cyc >= free_at[d]);
      e_ii  = int'(m_addr[31:28]);
      e_map = (e_ii < 4);
      e_az  = {4'h0, m_addr[27:0]};
      e_acc = rst_n && req[d] && e_rdy;
      e_we  = '0;
      e_re  = '0;
      if (e_acc && e_map) begin
        if (m_we != 4'h0) e_we[e_ii*4 +: 4] = m_we;
        else              e_re[e_ii] = 1'b1;
      end
      e_rv = 1'b0;
      e_er = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i][66] == d[0] && exp_q[i][65:34] == 32'(cyc)) begin
          e_rv = exp_q[i][33];
          e_er = exp_q[i][32];
          if (e_rv) last_rd[d] = exp_q[i][31:0];
          exp_q.delete(i);
          break;
        end
      end
      if (mvalid) begin
        chk("m_ready", d, ready[d], e_rdy);
        chk("m_rvalid", d, rvalid[d], e_rv);
        chk("m_err", d, err[d], e_er);
        chk("m_rdata", d, rdata[d], last_rd[d]);
        chk("s_we", d, s_we[d], e_we);
        chk("s_re", d, s_re[d], e_re);
        chk("s_wdata", d, s_wdata[d], {4{m_wdata}});
        if (e_rdy) begin
          for (int k = 0; k < 4; k++) chk("s_addr_idle", d, s_addr[d][k*32 +: 32], e_az);
        end else if (cyc >= rw_lo[d] && cyc <= rw_hi[d]) begin
          chk("s_addr_hold", d, s_addr[d][lat_idx[d]*32 +: 32], lat_addr[d]);
        end
`ifdef BUS_STATS_EN
        chk("stat_rd", d, st_rd[d], sat16(n_rd[d]));
        chk("stat_wr", d, st_wr[d], sat16(n_wr[d]));
        chk("stat_err", d, st_err[d], sat16(n_er[d]));
`else
        chk("stat_rd", d, st_rd[d], 16'h0);
        chk("stat_wr", d, st_wr[d], 16'h0);
        chk("stat_err", d, st_err[d], 16'h0);
`endif
      end
      if (!rst_n) begin
        free_at[d] = 0; rw_lo[d] = 0; rw_hi[d] = -1; last_rd[d] = '0;
        n_rd[d] = 0; n_wr[d] = 0; n_er[d] = 0;
      end else if (e_acc) begin
        if (m_we != 4'h0) begin
          if (e_map) n_wr[d]++;
          else begin
            n_er[d]++;
            exp_q.push_back({d[0], 32'(cyc + 1), 1'b0, 1'b1, 32'h0});
          end
        end else if (e_map) begin
          n_rd[d]++;
          exp_q.push_back({d[0], 32'(cyc + lat_of(d) + 1), 1'b1, 1'b0, slave_data(e_ii, e_az)});
          free_at[d] = cyc + lat_of(d) + 2;
          rw_lo[d] = cyc + 1; rw_hi[d] = cyc + lat_of(d);
          lat_idx[d] = e_ii; lat_addr[d] = e_az;
        end else begin
          n_er[d]++;
          exp_q.push_back({d[0], 32'(cyc + 1), 1'b1, 1'b1, 32'h0});
          free_at[d] = cyc + 2;
        end
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      mvalid = 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  logic [68:0] tbl[8] = '{
    {1'b0, 4'h1, 32'h0000_0004, 32'h1111_1111},
    {1'b1, 4'hC, 32'h3000_0080, 32'h2222_2222},
    {1'b0, 4'h0, 32'h3000_0100, 32'h0},
    {1'b1, 4'h0, 32'h0000_0200, 32'h0},
    {1'b1, 4'h0, 32'hF000_0000, 32'h0},
    {1'b0, 4'h6, 32'h8000_0010, 32'h3333_3333},
    {1'b1, 4'h0, 32'h2000_0004, 32'h0},
    {1'b0, 4'h0, 32'h1FFF_FFFC, 32'h0}
  };

  initial begin
    int a1, a2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 0, ready[0], 1'b1);
    chk("rst_rvalid", 0, rvalid[0], 1'b0);
    chk("rst_rdata", 0, rdata[0], 32'h0);
    chk("rst_err", 0, err[0], 1'b0);

    // Mapped write to slave 1: same-cycle byte enables, select field zeroed.
    do_req(0, 4'hF, 32'h1000_0010, 32'hDEAD_BEEF, 1'b0, a1);
    chk("wr_s_we", 0, acc_we, 16'h00F0);
    chk("wr_s_addr1", 0, acc_addr[63:32], 32'h0000_0010);

    // Latency-1 read from slave 2.
    do_req(0, 4'h0, 32'h2000_0004, 32'h0, 1'b0, a1);
    chk("rd_s_re", 0, acc_re, 4'b0100);
    @(negedge clk);
    chk("rd_busy_t1", 0, ready[0], 1'b0);
    @(negedge clk);
    chk("rd_rvalid_t2", 0, rvalid[0], 1'b1);
    chk("rd_rdata_t2", 0, rdata[0], 32'h1234_5678);
    chk("rd_err_t2", 0, err[0], 1'b0);
    chk("rd_busy_t2", 0, ready[0], 1'b0);

    do_req(0, 4'h3, 32'h3000_0100, 32'hCAFE_0001, 1'b0, a1);
    do_req(0, 4'h1, 32'h0000_0008, 32'hCAFE_0002, 1'b0, a1);
    do_req(0, 4'h0, 32'h1000_0020, 32'h0, 1'b0, a1);
    repeat (2) @(negedge clk);

    // Unmapped read and write.
    do_req(0, 4'h0, 32'h7000_0000, 32'h0, 1'b0, a1);
    chk("ur_s_re", 0, acc_re, 4'b0000);
    @(negedge clk);
    chk("ur_rvalid", 0, rvalid[0], 1'b1);
    chk("ur_err", 0, err[0], 1'b1);
    chk("ur_rdata", 0, rdata[0], 32'h0);
`ifdef BUS_STATS_EN
    chk("stat_wr_lit", 0, st_wr[0], 16'd3);
    chk("stat_rd_lit", 0, st_rd[0], 16'd2);
    chk("stat_err_lit", 0, st_err[0], 16'd1);
`endif
    do_req(0, 4'hF, 32'h5000_0000, 32'h0, 1'b0, a1);
    chk("uw_s_we", 0, acc_we, 16'h0000);
    @(negedge clk);
    chk("uw_err", 0, err[0], 1'b1);
    chk("uw_rvalid", 0, rvalid[0], 1'b0);

    // Latency-3 back-to-back reads with the request held.
    do_req(1, 4'h0, 32'h1000_0040, 32'h0, 1'b1, a1);
    m_addr = 32'h3000_0044;
    @(negedge clk);
    chk("rw_addr_hold", 1, s_addr[1][63:32], 32'h0000_0040);
    do_req(1, 4'h0, 32'h3000_0044, 32'h0, 1'b0, a2);
    chk("b2b_spacing", 1, a2 - a1, 5);
    repeat (6) @(negedge clk);

    // Reset during RD_WAIT discards the read.
    do_req(1, 4'h0, 32'h2000_0008, 32'h0, 1'b0, a1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_rvalid", 1, rvalid[1], 1'b0);
      chk("rst_mid_ready", 1, ready[1], 1'b1);
    end

    for (int i = 0; i < 8; i++) begin
      do_req(int'(tbl[i][68]), tbl[i][67:64], tbl[i][63:32], tbl[i][31:0], 1'b0, a1);
    end
    repeat (6) @(negedge clk);

`ifdef BUS_STATS_EN
    for (int i = 0; i < 65536; i++) do_req(0, 4'hF, 32'h0000_0000, 32'(i), 1'b1, a1);
    m_req = 1'b0;
    @(negedge clk);
    chk("stat_wr_sat", 0, st_wr[0], 16'hFFFF);
`endif

    repeat (8) @(negedge clk);
    chk("drain", 0, exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
